// File: rtl/deserializer_pkg.sv
// Shared lane-numbering definitions for the 4:1 word serializer and its
// receive-side deserializer.
package deserializer_pkg;

    localparam int LANES = 4;

    typedef logic [$clog2(LANES)-1:0] lane_idx_t;

    localparam lane_idx_t LAST_LANE = 2'd3;

endpackage : deserializer_pkg

// File: rtl/deserializer_out_reg.sv
// Single-entry holding register for a reassembled four-lane frame.
// A load and a drain on the same edge replace the frame without a bubble.
module deser_out_reg #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_lane0,
    input  logic [WIDTH-1:0] i_lane1,
    input  logic [WIDTH-1:0] i_lane2,
    input  logic [WIDTH-1:0] i_lane3,
    input  logic             i_outReady,
    output logic [WIDTH-1:0] o_data0,
    output logic [WIDTH-1:0] o_data1,
    output logic [WIDTH-1:0] o_data2,
    output logic [WIDTH-1:0] o_data3,
    output logic             o_valid,
    output logic             o_full,
    output logic             o_drain
);

    logic [WIDTH-1:0] r_data0;
    logic [WIDTH-1:0] r_data1;
    logic [WIDTH-1:0] r_data2;
    logic [WIDTH-1:0] r_data3;
    logic             r_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_data2 <= '0;
            r_data3 <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data0 <= i_lane0;
            r_data1 <= i_lane1;
            r_data2 <= i_lane2;
            r_data3 <= i_lane3;
            r_valid <= 1'b1;
        end else if (r_valid && i_outReady) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data0 = r_data0;
    assign o_data1 = r_data1;
    assign o_data2 = r_data2;
    assign o_data3 = r_data3;
    assign o_valid = r_valid;
    assign o_full  = r_valid;
    assign o_drain = r_valid & i_outReady;

endmodule : deser_out_reg

// File: rtl/deserializer.sv
// Reassembles a lane-0..3 word stream into parallel frames, with SOF-based
// framing recovery and a one-cycle error pulse on violations.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    input  logic             i_sof,
    output logic             o_inReady,
    output logic [WIDTH-1:0] o_data0,
    output logic [WIDTH-1:0] o_data1,
    output logic [WIDTH-1:0] o_data2,
    output logic [WIDTH-1:0] o_data3,
    output logic             o_valid,
    input  logic             i_outReady,
    output logic             o_err
);

    lane_idx_t        r_cnt;
    logic [WIDTH-1:0] r_stage0;
    logic [WIDTH-1:0] r_stage1;
    logic [WIDTH-1:0] r_stage2;
    logic             r_err;

    logic w_full;
    logic w_drain;
    logic w_inReady;
    logic w_accept;
    logic w_earlySof;
    logic w_missingSof;
    logic w_goodAccept;
    logic w_load;

    // Only the closing lane can stall: it needs the output register free.
    assign w_inReady    = (r_cnt != LAST_LANE) | ~w_full | w_drain;
    assign w_accept     = i_valid & w_inReady;
    assign w_earlySof   = w_accept & i_sof & (r_cnt != '0);
    assign w_missingSof = w_accept & ~i_sof & (r_cnt == '0);
    assign w_goodAccept = w_accept & ~w_earlySof & ~w_missingSof;
    assign w_load       = w_goodAccept & (r_cnt == LAST_LANE);

    // An early SOF restarts the frame with the current word as lane 0.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_stage0 <= '0;
            r_stage1 <= '0;
            r_stage2 <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_earlySof | w_missingSof;
            if (w_earlySof) begin
                r_stage0 <= i_data;
                r_cnt    <= lane_idx_t'(1);
            end else if (w_goodAccept) begin
                case (r_cnt)
                    2'd0:    r_stage0 <= i_data;
                    2'd1:    r_stage1 <= i_data;
                    2'd2:    r_stage2 <= i_data;
                    default: ;
                endcase
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    deser_out_reg #(
        .WIDTH (WIDTH)
    ) u_outReg (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_lane0    (r_stage0),
        .i_lane1    (r_stage1),
        .i_lane2    (r_stage2),
        .i_lane3    (i_data),
        .i_outReady (i_outReady),
        .o_data0    (o_data0),
        .o_data1    (o_data1),
        .o_data2    (o_data2),
        .o_data3    (o_data3),
        .o_valid    (o_valid),
        .o_full     (w_full),
        .o_drain    (w_drain)
    );

    assign o_inReady = w_inReady;
    assign o_err     = r_err;

endmodule : deserializer

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side counterpart of the 4:1 word serializer.
- Accepts a stream of WIDTH-bit words, one lane per accepted beat: lane 0, 1, 2, 3, repeating.
- Reassembles each group of four into a parallel frame on O0..O3, framed by I_SOF on lane 0.
- Valid/ready handshake on both sides; single-entry output register; one-cycle ERR pulse on framing violations.

Parameters:
- WIDTH, 16, bit width of each serial word and each parallel output lane.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- I  input  WIDTH  serial data word.
- I_VALID  input  1  I and I_SOF valid this cycle.
- I_SOF  input  1  high on the lane-0 word of each frame.
- I_READY  output  1  block accepts I this cycle.
- O0  output  WIDTH  frame lane 0, the first word accepted.
- O1  output  WIDTH  frame lane 1.
- O2  output  WIDTH  frame lane 2.
- O3  output  WIDTH  frame lane 3, the last word accepted.
- O_VALID  output  1  O0..O3 hold a complete frame.
- O_READY  input  1  downstream consumes the frame this cycle.
- ERR  output  1  one-cycle pulse: framing violation detected.

Behaviour:
- Reset (synchronous, RESET high at a CLK edge) clears all state:
  - cnt=0, staging regs s0..s2=0, O0..O3=0, O_VALID=0, ERR=0.
  - A partial frame in progress is discarded.
  - RESET overrides all other inputs in that cycle.
- Accept: acc = I_VALID & I_READY.
- I_READY is combinational: (cnt!=3) | ~O_VALID | O_READY.
  - Lanes 0-2 are always accepted.
  - Lane 3 stalls only while a previous frame is still held and not being drained.
- cnt: 2-bit index of the next expected lane. Increments on a good acc and wraps 3->0.
- Good acc with cnt in {0,1,2}: I is stored into s[cnt].
- Good acc with cnt==3, on the next edge:
  - O0<=s0, O1<=s1, O2<=s2, O3<=I.
  - O_VALID<=1, cnt<=0.
  - Latency: last word accepted -> O_VALID high one cycle later.
- Output hold:
  - While O_VALID=1 and O_READY=0, O0..O3 and O_VALID are stable.
  - O_VALID falls after an edge with O_READY=1, unless a new frame loads on that same edge.
  - Simultaneous drain and load: the new frame replaces the old one and O_VALID stays 1, with no bubble.
- Sustained throughput: one frame per 4 cycles with I_VALID=1 and O_READY=1.
- Framing check, on every acc:
  - I_SOF=1 with cnt!=0 (early SOF): partial frame abandoned, I stored as lane 0 (s0), cnt<=1, ERR<=1.
  - I_SOF=0 with cnt==0 (missing SOF, hunting): word dropped, cnt stays 0, ERR<=1.
  - Otherwise ERR<=0. ERR is registered, so it is high exactly one cycle after the offending acc.
- Discarded or dropped words never reach O0..O3.
- Existing O_VALID content is unaffected by framing errors.
- I, I_SOF and O_READY are ignored when not used.
- O0..O3 values when O_VALID=0 are don't-care for checking, but in practice hold their last values.

Decomposition:
- Shared package:
  - LANES=4.
  - lane_idx_t as a 2-bit typedef.
  - LAST_LANE=2'd3.
  - Same package used by the serializer for its lane counter.
- One natural sub-module, deser_out_reg: the single-entry output holding register.
  - Inputs: load, four lane words, O_READY.
  - Outputs: O0..O3 and O_VALID.
  - Exports full/drain so the parent computes I_READY.
- Counter, staging registers and framing check stay in deserializer.

Test Plan:
- Reset: hold RESET 2 cycles with I_VALID=1 -> O_VALID=0, ERR=0, O0..O3=0, I_READY=1 throughout.
- Basic frame: O_READY=1; feed 0x1111(SOF), 0x2222, 0x3333, 0x4444 on consecutive cycles -> one cycle after the 4th word, O_VALID=1 with O0..O3=0x1111,0x2222,0x3333,0x4444; ERR never set.
- Backpressure: O_READY=0; send two back-to-back frames (A: 0xA000..0xA003, B: 0xB000..0xB003):
  - I_READY drops while B lane 3 is presented; frame A is held stable.
  - Raise O_READY -> A is consumed and B loads on that same edge; O_VALID stays 1; no words are lost.
- Early SOF: send 0x0001(SOF), 0x0002, then 0x0010(SOF), 0x0011, 0x0012, 0x0013:
  - ERR pulses once, one cycle after 0x0010 is accepted.
  - Output frame is 0x0010,0x0011,0x0012,0x0013.
- Missing SOF: send 0x5555, 0x6666 with SOF=0 from idle, then a good frame:
  - ERR pulses for each of the two words.
  - Only the good frame appears on the outputs.
- Reset mid-frame: after lanes 0-1 are accepted, pulse RESET for 1 cycle, then send a full frame -> output equals the new frame only; O_VALID never asserts for the partial frame.
